// File: rtl/psk_frame_sched.sv
// Frame scheduler for the PSK modulator: BPSK preamble, BPSK/QPSK payload, silent guard gap.
// Symbol slots are paced by the modulator's mod_tready strobe; a one-entry byte buffer prefetches payload.
module psk_frame_sched #(
  parameter int unsigned PRE_LEN = 32,
  parameter logic [31:0] PRE_SEQ = 32'hA5F03C96,
  parameter int unsigned GAP_LEN = 8
) (
  input  logic        clk_16M384,
  input  logic        rst_n_16M384,
  input  logic        en,
  input  logic        cfg_is_bpsk,
  input  logic [7:0]  in_tdata,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic        in_tlast,
  output logic [7:0]  mod_tdata,
  output logic        mod_tvalid,
  input  logic        mod_tready,
  output logic        mod_tlast,
  output logic        mod_tuser,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun,
  input  logic        clr_err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned GAP_W = 8;
  localparam int unsigned REM_W = 3;

  typedef enum logic [1:0] {IDLE, PRE, PAY, GAP} state_t;

  state_t             state, state_nxt;
  logic               mode, mode_nxt;
  logic [IDX_W-1:0]   pre_idx, pre_idx_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic [7:0]         sh, sh_nxt;
  logic [REM_W-1:0]   sym_rem, sym_rem_nxt;
  logic               cur_last, cur_last_nxt;
  logic               buf_valid, buf_valid_nxt;
  logic [7:0]         buf_data, buf_data_nxt;
  logic               buf_last, buf_last_nxt;
  logic               last_taken, last_taken_nxt;

  logic [7:0]         mod_tdata_nxt;
  logic               mod_tvalid_nxt, mod_tlast_nxt, mod_tuser_nxt;
  logic               in_tready_nxt, busy_nxt, frame_done_nxt, underrun_nxt;
  logic [15:0]        frame_cnt_nxt;

  logic               in_fire, need_byte, have_byte, new_last;
  logic [7:0]         new_data;

  // State and output registers
  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      state      <= IDLE;
      mode       <= 1'b0;
      pre_idx    <= '0;
      gap_cnt    <= '0;
      sh         <= '0;
      sym_rem    <= '0;
      cur_last   <= 1'b0;
      buf_valid  <= 1'b0;
      buf_data   <= '0;
      buf_last   <= 1'b0;
      last_taken <= 1'b0;
      mod_tdata  <= '0;
      mod_tvalid <= 1'b0;
      mod_tlast  <= 1'b0;
      mod_tuser  <= 1'b0;
      in_tready  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      mode       <= mode_nxt;
      pre_idx    <= pre_idx_nxt;
      gap_cnt    <= gap_cnt_nxt;
      sh         <= sh_nxt;
      sym_rem    <= sym_rem_nxt;
      cur_last   <= cur_last_nxt;
      buf_valid  <= buf_valid_nxt;
      buf_data   <= buf_data_nxt;
      buf_last   <= buf_last_nxt;
      last_taken <= last_taken_nxt;
      mod_tdata  <= mod_tdata_nxt;
      mod_tvalid <= mod_tvalid_nxt;
      mod_tlast  <= mod_tlast_nxt;
      mod_tuser  <= mod_tuser_nxt;
      in_tready  <= in_tready_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      underrun   <= underrun_nxt;
      frame_cnt  <= frame_cnt_nxt;
    end
  end

  // Next-state, symbol selection and byte buffer
  always_comb begin
    state_nxt      = state;
    mode_nxt       = mode;
    pre_idx_nxt    = pre_idx;
    gap_cnt_nxt    = gap_cnt;
    sh_nxt         = sh;
    sym_rem_nxt    = sym_rem;
    cur_last_nxt   = cur_last;
    buf_valid_nxt  = buf_valid;
    buf_data_nxt   = buf_data;
    buf_last_nxt   = buf_last;
    last_taken_nxt = last_taken;
    mod_tdata_nxt  = mod_tdata;
    mod_tvalid_nxt = mod_tvalid;
    mod_tlast_nxt  = mod_tlast;
    mod_tuser_nxt  = mod_tuser;
    frame_done_nxt = 1'b0;
    frame_cnt_nxt  = frame_cnt;
    underrun_nxt   = underrun & ~clr_err;
    need_byte      = 1'b0;

    in_fire   = in_tvalid & in_tready;
    have_byte = buf_valid | in_fire;
    new_data  = buf_valid ? buf_data : in_tdata;
    new_last  = buf_valid ? buf_last : in_tlast;

    if (in_fire && in_tlast) begin
      last_taken_nxt = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (en && in_tvalid) begin
          state_nxt      = PRE;
          mode_nxt       = cfg_is_bpsk;
          pre_idx_nxt    = '0;
          last_taken_nxt = 1'b0;
          mod_tvalid_nxt = 1'b1;
          mod_tuser_nxt  = 1'b1;
          mod_tlast_nxt  = 1'b0;
          mod_tdata_nxt  = {6'b0, PRE_SEQ[0], 1'b0};
        end
      end
      PRE: begin
        if (mod_tready) begin
          if (32'(pre_idx) == PRE_LEN - 1) begin
            state_nxt = PAY;
            need_byte = 1'b1;
          end else begin
            pre_idx_nxt   = pre_idx + IDX_W'(1);
            mod_tdata_nxt = {6'b0, PRE_SEQ[pre_idx + IDX_W'(1)], 1'b0};
          end
        end
      end
      PAY: begin
        if (mod_tready) begin
          if (mod_tvalid && mod_tlast) begin
            state_nxt      = GAP;
            gap_cnt_nxt    = '0;
            mod_tvalid_nxt = 1'b0;
            mod_tdata_nxt  = '0;
            mod_tlast_nxt  = 1'b0;
            mod_tuser_nxt  = 1'b0;
          end else if (mod_tvalid && sym_rem != '0) begin
            sym_rem_nxt   = sym_rem - REM_W'(1);
            mod_tlast_nxt = cur_last && (sym_rem == REM_W'(1));
            if (mode) begin
              mod_tdata_nxt = {6'b0, sh[7], 1'b0};
              sh_nxt        = sh << 1;
            end else begin
              mod_tdata_nxt = {6'b0, sh[7:6]};
              sh_nxt        = sh << 2;
            end
          end else begin
            need_byte = 1'b1;
          end
        end
      end
      GAP: begin
        if (mod_tready) begin
          if (32'(gap_cnt) == GAP_LEN - 1) begin
            state_nxt      = IDLE;
            frame_done_nxt = 1'b1;
            frame_cnt_nxt  = frame_cnt + 16'd1;
          end else begin
            gap_cnt_nxt = gap_cnt + GAP_W'(1);
          end
        end
      end
    endcase

    // First symbol of a fresh byte, or a silent slot when the FIFO fell behind
    if (need_byte) begin
      mod_tuser_nxt = mode;
      mod_tlast_nxt = 1'b0;
      if (have_byte) begin
        mod_tvalid_nxt = 1'b1;
        cur_last_nxt   = new_last;
        if (mode) begin
          mod_tdata_nxt = {6'b0, new_data[7], 1'b0};
          sh_nxt        = new_data << 1;
          sym_rem_nxt   = REM_W'(7);
        end else begin
          mod_tdata_nxt = {6'b0, new_data[7:6]};
          sh_nxt        = new_data << 2;
          sym_rem_nxt   = REM_W'(3);
        end
      end else begin
        mod_tvalid_nxt = 1'b0;
        mod_tdata_nxt  = '0;
        underrun_nxt   = 1'b1;
      end
    end

    // Consume before load: an arriving byte bypasses the buffer only when needed this cycle
    if (need_byte && buf_valid) begin
      buf_valid_nxt = 1'b0;
    end
    if (in_fire && !(need_byte && !buf_valid)) begin
      buf_valid_nxt = 1'b1;
      buf_data_nxt  = in_tdata;
      buf_last_nxt  = in_tlast;
    end

    in_tready_nxt = ((state_nxt == PRE) || (state_nxt == PAY)) && !buf_valid_nxt && !last_taken_nxt;
    busy_nxt      = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_psk_frame_sched.sv
// Scoreboard bench for psk_frame_sched: expected symbols are queued by the stimulus,
// a negedge monitor pops and compares on every consumed modulator slot.
module tb_psk_frame_sched;

  localparam int unsigned GAP_LEN = 8;
  localparam logic [31:0] PRE_SEQ = 32'hA5F03C96;

  typedef struct packed {
    logic [7:0] data;
    logic       tuser;
    logic       tlast;
  } sym_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         delay;
  } byte_t;

  logic        clk_16M384 = 1'b0;
  logic        rst_n_16M384 = 1'b0;
  logic        en = 1'b0;
  logic        cfg_is_bpsk = 1'b1;
  logic [7:0]  in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic        in_tlast;
  logic [7:0]  mod_tdata;
  logic        mod_tvalid;
  logic        mod_tready;
  logic        mod_tlast;
  logic        mod_tuser;
  logic        busy;
  logic        frame_done;
  logic        underrun;
  logic        clr_err = 1'b0;
  logic [15:0] frame_cnt;

  psk_frame_sched dut (
    .clk_16M384   (clk_16M384),
    .rst_n_16M384 (rst_n_16M384),
    .en           (en),
    .cfg_is_bpsk  (cfg_is_bpsk),
    .in_tdata     (in_tdata),
    .in_tvalid    (in_tvalid),
    .in_tready    (in_tready),
    .in_tlast     (in_tlast),
    .mod_tdata    (mod_tdata),
    .mod_tvalid   (mod_tvalid),
    .mod_tready   (mod_tready),
    .mod_tlast    (mod_tlast),
    .mod_tuser    (mod_tuser),
    .busy         (busy),
    .frame_done   (frame_done),
    .underrun     (underrun),
    .clr_err      (clr_err),
    .frame_cnt    (frame_cnt)
  );

  always #30 clk_16M384 = ~clk_16M384;

  int    n_checks = 0;
  int    n_pass = 0;
  sym_t  exp_q[$];
  byte_t fifo_q[$];
  int    wait_cnt = 0;
  logic  in_gap = 1'b0;
  logic  after_last = 1'b0;
  int    slots_since = 0;
  int    last_between = 0;
  int    gap_slots = 0;
  int    hole_cnt = 0;
  int    sym_seen = 0;
  int    done_cnt = 0;
  int    exp_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_pre();
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back('{data: {6'b0, PRE_SEQ[i], 1'b0}, tuser: 1'b1, tlast: 1'b0});
    end
  endtask

  // syms: hand-written 2-bit symbols, first symbol in bits [15:14]
  task automatic push_pay(input logic [15:0] syms, input int n, input logic tuser, input logic last);
    logic [1:0] v;
    for (int i = 0; i < n; i++) begin
      v = syms[15 - 2*i -: 2];
      exp_q.push_back('{data: {6'b0, v}, tuser: tuser, tlast: last && (i == n - 1)});
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int i = 0;
    while (done_cnt < target && i < budget) begin
      @(posedge clk_16M384);
      i++;
    end
    check({name, "_done"}, 32'(done_cnt >= target), 32'd1);
    repeat (4) @(posedge clk_16M384);
    #1;
  endtask

  // Modulator strobe: one cycle every 16
  initial begin
    mod_tready = 1'b0;
    forever begin
      repeat (15) @(posedge clk_16M384);
      #1 mod_tready = 1'b1;
      @(posedge clk_16M384);
      #1 mod_tready = 1'b0;
    end
  end

  // TX FIFO model; an entry's delay counts ready cycles before it is offered
  initial begin
    in_tvalid = 1'b0;
    in_tdata  = '0;
    in_tlast  = 1'b0;
    forever begin
      @(posedge clk_16M384);
      if (in_tvalid && in_tready) begin
        check("fetch_in_gap", 32'(in_gap), 32'd0);
        void'(fifo_q.pop_front());
        wait_cnt = 0;
      end else if (fifo_q.size() > 0 && in_tready) begin
        wait_cnt++;
      end
      #1;
      if (fifo_q.size() > 0 && wait_cnt >= fifo_q[0].delay) begin
        in_tvalid = 1'b1;
        in_tdata  = fifo_q[0].data;
        in_tlast  = fifo_q[0].last;
      end else begin
        in_tvalid = 1'b0;
        in_tdata  = '0;
        in_tlast  = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk_16M384) begin
    sym_t e;
    if (mod_tvalid) in_gap = 1'b0;
    if (mod_tready) begin
      if (mod_tvalid) begin
        sym_seen++;
        if (after_last) begin
          last_between = slots_since;
          after_last = 1'b0;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_symbol", 32'({mod_tdata, mod_tuser, mod_tlast}), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("sym%0d", sym_seen), 32'({mod_tdata, mod_tuser, mod_tlast}), 32'(e));
        end
        if (mod_tlast) begin
          in_gap = 1'b1;
          after_last = 1'b1;
          slots_since = 0;
          gap_slots = 0;
        end
      end else begin
        slots_since++;
        if (busy) begin
          if (in_gap) gap_slots++;
          else hole_cnt++;
        end
      end
    end
    if (frame_done) begin
      done_cnt++;
      check("gap_slots", 32'(gap_slots), 32'(GAP_LEN));
    end
  end

  initial begin
    #(60 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int target;
    int hole_base;
    int base;
    int i;

    // T1: reset held with FIFO valid, then en=0
    fifo_q.push_back('{data: 8'hC5, last: 1'b1, delay: 0});
    repeat (5) @(posedge clk_16M384);
    @(negedge clk_16M384);
    check("t1_rst_in_tvalid_seen", 32'(in_tvalid), 32'd1);
    check("t1_rst_outputs", 32'({in_tready, mod_tvalid, mod_tdata, mod_tlast, mod_tuser,
                                 busy, frame_done, underrun}), 32'd0);
    check("t1_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk_16M384);
    #1 rst_n_16M384 = 1'b1;
    repeat (40) @(posedge clk_16M384);
    @(negedge clk_16M384);
    check("t1_en0_in_tready", 32'(in_tready), 32'd0);
    check("t1_en0_busy", 32'(busy), 32'd0);

    // T2: BPSK frame, byte C5 -> 1,1,0,0,0,1,0,1
    @(posedge clk_16M384);
    #1;
    cfg_is_bpsk = 1'b1;
    push_pre();
    push_pay(16'hA022, 8, 1'b1, 1'b1);
    target = done_cnt + 1;
    en = 1'b1;
    wait_frames(target, 3000, "t2");
    exp_frames++;
    check("t2_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("t2_done_pulse", 32'(done_cnt), 32'(target));
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);

    // T3: QPSK frame 1B, E4 -> 00,01,10,11,11,10,01,00
    cfg_is_bpsk = 1'b0;
    hole_base = hole_cnt;
    push_pre();
    push_pay(16'h1BE4, 8, 1'b0, 1'b1);
    fifo_q.push_back('{data: 8'h1B, last: 1'b0, delay: 0});
    fifo_q.push_back('{data: 8'hE4, last: 1'b1, delay: 0});
    target = done_cnt + 1;
    wait_frames(target, 3000, "t3");
    exp_frames++;
    check("t3_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t3_no_hole", 32'(hole_cnt), 32'(hole_base));
    check("t3_no_underrun", 32'(underrun), 32'd0);

    // T4: QPSK 6C, 93 with the second byte held back past its slot
    hole_base = hole_cnt;
    push_pre();
    push_pay(16'h6C93, 8, 1'b0, 1'b1);
    fifo_q.push_back('{data: 8'h6C, last: 1'b0, delay: 0});
    fifo_q.push_back('{data: 8'h93, last: 1'b1, delay: 100});
    target = done_cnt + 1;
    wait_frames(target, 3000, "t4");
    exp_frames++;
    check("t4_hole_seen", 32'(hole_cnt > hole_base), 32'd1);
    check("t4_underrun_sticky", 32'(underrun), 32'd1);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t4_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    clr_err = 1'b1;
    @(posedge clk_16M384);
    #1 clr_err = 1'b0;
    @(negedge clk_16M384);
    check("t4_underrun_cleared", 32'(underrun), 32'd0);

    // T5: two BPSK packets queued back-to-back: 0F then F0
    cfg_is_bpsk = 1'b1;
    push_pre();
    push_pay(16'h00AA, 8, 1'b1, 1'b1);
    push_pre();
    push_pay(16'hAA00, 8, 1'b1, 1'b1);
    fifo_q.push_back('{data: 8'h0F, last: 1'b1, delay: 0});
    fifo_q.push_back('{data: 8'hF0, last: 1'b1, delay: 0});
    target = done_cnt + 2;
    wait_frames(target, 6000, "t5");
    exp_frames += 2;
    check("t5_gap_between", 32'(last_between), 32'(GAP_LEN));
    check("t5_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // T6: reset while payload symbol 3 is on the bus, then a fresh frame
    push_pre();
    push_pay(16'h8888, 3, 1'b1, 1'b0);
    fifo_q.push_back('{data: 8'hAA, last: 1'b1, delay: 0});
    base = sym_seen;
    i = 0;
    while (sym_seen < base + 35 && i < 3000) begin
      @(negedge clk_16M384);
      i++;
    end
    check("t6_reached_pay3", 32'(sym_seen >= base + 35), 32'd1);
    #5 rst_n_16M384 = 1'b0;
    #1;
    check("t6_rst_outputs", 32'({in_tready, mod_tvalid, mod_tdata, mod_tlast, mod_tuser,
                                 busy, frame_done, underrun}), 32'd0);
    check("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk_16M384);
    #1 rst_n_16M384 = 1'b1;
    exp_frames = 0;
    push_pre();
    push_pay(16'h2288, 8, 1'b1, 1'b1);
    fifo_q.push_back('{data: 8'h5A, last: 1'b1, delay: 0});
    target = done_cnt + 1;
    wait_frames(target, 3000, "t6");
    exp_frames++;
    check("t6_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("t6_queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
